// File: rtl/jam_perm_engine.sv
// jam_perm_engine: exhaustive N! job-assignment search over an external synchronous cost ROM.
// Optional JAM_BEST_PERM_EN adds the BestPerm output (lexicographically first optimal assignment).

module jam_perm_engine #(
  parameter  int N       = 8,
  parameter  int COST_W  = 7,
  parameter  int MATCH_W = 16,
  localparam int IDX_W   = $clog2(N),
  localparam int SUM_W   = COST_W + $clog2(N)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  output logic               Busy,
  output logic [IDX_W-1:0]   W,
  output logic [IDX_W-1:0]   J,
  input  logic [COST_W-1:0]  Cost,
  output logic [SUM_W-1:0]   MinCost,
  output logic [MATCH_W-1:0] MatchCount,
  output logic               Valid
`ifdef JAM_BEST_PERM_EN
  ,
  output logic [N*IDX_W-1:0] BestPerm
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_PERMUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, nxt_idx;
  logic [IDX_W-1:0] perm_q  [N];
  logic [IDX_W-1:0] swp     [N];
  logic [IDX_W-1:0] perm_nx [N];
  logic [IDX_W-1:0] pivot_q, succ_q;
  logic             have_pivot_q;
  logic [SUM_W-1:0] acc_q, cand_q;
  logic             cand_vld_q;
  logic             start_acc;
`ifdef JAM_BEST_PERM_EN
  logic [IDX_W-1:0] cand_perm_q [N];
`endif

  assign start_acc = Start && !Busy && (state_q == S_IDLE || state_q == S_DONE);
  assign nxt_idx   = idx_q + IDX_W'(1);

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_acc) state_d = S_ISSUE;
      S_ISSUE:   if (idx_q == LAST) state_d = S_PERMUTE;
      S_PERMUTE: state_d = have_pivot_q ? S_ISSUE : S_DRAIN;
      S_DRAIN:   state_d = S_DONE;
      S_DONE:    if (start_acc) state_d = S_ISSUE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Lexicographic successor: swap pivot with successor, then reverse the descending suffix.
  always_comb begin
    swp          = perm_q;
    swp[pivot_q] = perm_q[succ_q];
    swp[succ_q]  = perm_q[pivot_q];
    perm_nx      = swp;
    for (int k = 0; k < N; k++) begin
      if (IDX_W'(k) > pivot_q) perm_nx[k] = swp[IDX_W'(N - 1 - k) + pivot_q + IDX_W'(1)];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q        <= '0;
      W            <= '0;
      J            <= '0;
      MinCost      <= '1;
      MatchCount   <= '0;
      Valid        <= 1'b0;
      Busy         <= 1'b0;
      acc_q        <= '0;
      cand_q       <= '0;
      cand_vld_q   <= 1'b0;
      pivot_q      <= '0;
      succ_q       <= '0;
      have_pivot_q <= 1'b0;
      // NOTE: the permutation array is a handful of flops, not a RAM, so it is reset to identity here.
      for (int i = 0; i < N; i++) perm_q[i] <= IDX_W'(i);
`ifdef JAM_BEST_PERM_EN
      BestPerm <= '0;
      for (int i = 0; i < N; i++) cand_perm_q[i] <= '0;
`endif
    end else begin
      cand_vld_q <= (state_q == S_PERMUTE);

      // Compare stage runs one cycle behind the candidate latch.
      if (cand_vld_q) begin
        if (cand_q < MinCost) begin
          MinCost    <= cand_q;
          MatchCount <= MATCH_W'(1);
`ifdef JAM_BEST_PERM_EN
          for (int i = 0; i < N; i++) BestPerm[i*IDX_W +: IDX_W] <= cand_perm_q[i];
`endif
        end else if (cand_q == MinCost && MatchCount != '1) begin
          MatchCount <= MatchCount + MATCH_W'(1);
        end
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_acc) begin
            MinCost      <= '1;
            MatchCount   <= '0;
            Valid        <= 1'b0;
            Busy         <= 1'b1;
            acc_q        <= '0;
            idx_q        <= '0;
            W            <= '0;
            J            <= '0;
            have_pivot_q <= 1'b0;
            for (int i = 0; i < N; i++) perm_q[i] <= IDX_W'(i);
`ifdef JAM_BEST_PERM_EN
            BestPerm <= '0;
`endif
          end else if (Busy) begin
            Valid <= 1'b1;
            Busy  <= 1'b0;
          end
        end
        S_ISSUE: begin
          // Cost for read idx-1 arrives now; read 0 has nothing pending.
          if (idx_q != '0) acc_q <= acc_q + SUM_W'(Cost);
          if (have_pivot_q && perm_q[idx_q] > perm_q[pivot_q]) succ_q <= idx_q;
          if (idx_q != LAST) begin
            if (perm_q[idx_q] < perm_q[nxt_idx]) begin
              pivot_q      <= idx_q;
              succ_q       <= nxt_idx;
              have_pivot_q <= 1'b1;
            end
            idx_q <= nxt_idx;
            W     <= nxt_idx;
            J     <= perm_q[nxt_idx];
          end
        end
        S_PERMUTE: begin
          cand_q       <= acc_q + SUM_W'(Cost);
          acc_q        <= '0;
          idx_q        <= '0;
          have_pivot_q <= 1'b0;
`ifdef JAM_BEST_PERM_EN
          cand_perm_q  <= perm_q;
`endif
          if (have_pivot_q) begin
            perm_q <= perm_nx;
            W      <= '0;
            J      <= perm_nx[0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_perm_engine.sv
// Self-checking bench for jam_perm_engine: four instances (N=2, N=3, N=3 with 2-bit counter, N=4),
// each fed by its own synchronous cost ROM; table-driven N=3 vectors plus directed multi-cycle sequences.

module tb_jam_perm_engine;

  logic clk = 1'b0;
  logic rst;
  logic rst4_x;
  logic start;
  int   sel;
  int   checks = 0;
  int   errors = 0;
  int   w_hist [8];
  int   j_hist [8];

  always #5 clk = ~clk;

  // N=2
  logic       start2, busy2, valid2;
  logic [0:0] w2, j2;
  logic [6:0] cost2;
  logic [7:0] min2;
  logic [15:0] cnt2;
  int         c2 [2][2];
  // N=3
  logic       start3, busy3, valid3;
  logic [1:0] w3, j3;
  logic [6:0] cost3;
  logic [8:0] min3;
  logic [15:0] cnt3;
  int         c3 [3][3];
  // N=3, MATCH_W=2
  logic       start3s, busy3s, valid3s;
  logic [1:0] w3s, j3s;
  logic [6:0] cost3s;
  logic [8:0] min3s;
  logic [1:0] cnt3s;
  // N=4
  logic       start4, busy4, valid4, rst4;
  logic [1:0] w4, j4;
  logic [6:0] cost4;
  logic [8:0] min4;
  logic [15:0] cnt4;
  int         c4 [4][4];
`ifdef JAM_BEST_PERM_EN
  logic [1:0] best2;
  logic [5:0] best3, best3s;
  logic [7:0] best4;
`endif

  assign start2  = start && (sel == 0);
  assign start3  = start && (sel == 1);
  assign start3s = start && (sel == 2);
  assign start4  = start && (sel == 3);
  assign rst4    = rst || rst4_x;

  jam_perm_engine #(.N(2)) u2 (
    .CLK(clk), .RST(rst), .Start(start2), .Busy(busy2), .W(w2), .J(j2), .Cost(cost2),
    .MinCost(min2), .MatchCount(cnt2), .Valid(valid2)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(best2)
`endif
  );
  jam_perm_engine #(.N(3)) u3 (
    .CLK(clk), .RST(rst), .Start(start3), .Busy(busy3), .W(w3), .J(j3), .Cost(cost3),
    .MinCost(min3), .MatchCount(cnt3), .Valid(valid3)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(best3)
`endif
  );
  jam_perm_engine #(.N(3), .MATCH_W(2)) u3s (
    .CLK(clk), .RST(rst), .Start(start3s), .Busy(busy3s), .W(w3s), .J(j3s), .Cost(cost3s),
    .MinCost(min3s), .MatchCount(cnt3s), .Valid(valid3s)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(best3s)
`endif
  );
  jam_perm_engine #(.N(4)) u4 (
    .CLK(clk), .RST(rst4), .Start(start4), .Busy(busy4), .W(w4), .J(j4), .Cost(cost4),
    .MinCost(min4), .MatchCount(cnt4), .Valid(valid4)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(best4)
`endif
  );

  // Synchronous cost ROMs: one cycle from W/J to Cost. u3 and u3s share the N=3 matrix.
  always_ff @(posedge clk) begin
    cost2  <= 7'(c2[w2][j2]);
    cost3  <= 7'(c3[w3][j3]);
    cost3s <= 7'(c3[w3s][j3s]);
    cost4  <= 7'(c4[w4][j4]);
  end

  logic        busy_m, valid_m;
  logic [15:0] min_m, cnt_m, ones_m;
  int          w_m, j_m;
  always_comb begin
    busy_m = 1'b0; valid_m = 1'b0; min_m = '0; cnt_m = '0; ones_m = '0; w_m = 0; j_m = 0;
    case (sel)
      0: begin busy_m = busy2;  valid_m = valid2;  min_m = 16'(min2);  cnt_m = cnt2;
               ones_m = 16'd255; w_m = int'(w2);  j_m = int'(j2);  end
      1: begin busy_m = busy3;  valid_m = valid3;  min_m = 16'(min3);  cnt_m = cnt3;
               ones_m = 16'd511; w_m = int'(w3);  j_m = int'(j3);  end
      2: begin busy_m = busy3s; valid_m = valid3s; min_m = 16'(min3s); cnt_m = 16'(cnt3s);
               ones_m = 16'd511; w_m = int'(w3s); j_m = int'(j3s); end
      default: begin busy_m = busy4; valid_m = valid4; min_m = 16'(min4); cnt_m = cnt4;
               ones_m = 16'd511; w_m = int'(w4); j_m = int'(j4); end
    endcase
  end

`ifdef JAM_BEST_PERM_EN
  int best_m;
  always_comb begin
    case (sel)
      0:       best_m = int'(best2);
      1:       best_m = int'(best3);
      2:       best_m = int'(best3s);
      default: best_m = int'(best4);
    endcase
  end
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse Start on instance s, optionally poke Start again while busy, then wait (bounded) for Valid.
  task automatic run(input int s, input int exp_cyc, input int exp_min, input int exp_cnt,
                     input int exp_best, input int poke_at, input string name);
    int cyc;
    sel = s;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, " valid cleared by start"}, int'(valid_m), 0);
    check({name, " busy after start"}, int'(busy_m), 1);
    check({name, " mincost cleared"}, int'(min_m), int'(ones_m));
    check({name, " matchcount cleared"}, int'(cnt_m), 0);
    cyc = 0;
    w_hist[0] = w_m;
    j_hist[0] = j_m;
    while (!valid_m && cyc < exp_cyc + 20) begin
      start = (cyc == poke_at);
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (cyc < 8) begin
        w_hist[cyc] = w_m;
        j_hist[cyc] = j_m;
      end
    end
    check({name, " valid latency"}, cyc, exp_cyc);
    check({name, " busy low at valid"}, int'(busy_m), 0);
    check({name, " mincost"}, int'(min_m), exp_min);
    check({name, " matchcount"}, int'(cnt_m), exp_cnt);
`ifdef JAM_BEST_PERM_EN
    check({name, " bestperm"}, best_m, exp_best);
`else
    if (exp_best < 0) $display("note: negative bestperm expectation for %s", name);
`endif
    repeat (3) @(posedge clk);
    #1;
    check({name, " valid held"}, int'(valid_m), 1);
    check({name, " mincost held"}, int'(min_m), exp_min);
  endtask

  typedef struct packed {
    logic [8:0][6:0] c;
    logic [8:0]      exp_min;
    logic [15:0]     exp_cnt;
    logic [5:0]      exp_best;
  } vec_t;

  vec_t tbl [6];

  initial begin
    rst = 1'b1;
    rst4_x = 1'b0;
    start = 1'b0;
    sel = 0;

    // N=3 vectors: costs stored row-major at index i*3+j.
    tbl[0].c = {9{7'd1}};
    tbl[0].exp_min = 9'd3;   tbl[0].exp_cnt = 16'd6; tbl[0].exp_best = 6'd36;
    for (int k = 0; k < 9; k++) tbl[1].c[k] = 7'(k);
    tbl[1].exp_min = 9'd12;  tbl[1].exp_cnt = 16'd6; tbl[1].exp_best = 6'd36;
    for (int k = 0; k < 9; k++) tbl[2].c[k] = (k % 4 == 0) ? 7'd9 : 7'd1;
    tbl[2].exp_min = 9'd3;   tbl[2].exp_cnt = 16'd2; tbl[2].exp_best = 6'd9;
    for (int k = 0; k < 9; k++) tbl[3].c[k] = (k == 2 || k == 4 || k == 6) ? 7'd0 : 7'd5;
    tbl[3].exp_min = 9'd0;   tbl[3].exp_cnt = 16'd1; tbl[3].exp_best = 6'd6;
    tbl[4].c = {9{7'd127}};
    tbl[4].exp_min = 9'd381; tbl[4].exp_cnt = 16'd6; tbl[4].exp_best = 6'd36;
    for (int k = 0; k < 9; k++) tbl[5].c[k] = (k % 4 == 0) ? 7'd0 : 7'd50;
    tbl[5].exp_min = 9'd0;   tbl[5].exp_cnt = 16'd1; tbl[5].exp_best = 6'd36;

    c2[0][0] = 1; c2[0][1] = 5; c2[1][0] = 5; c2[1][1] = 1;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) c3[i][j] = 1;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) c4[i][j] = (i + 2 * j) % 4;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check("reset valid", int'(valid_m), 0);
      check("reset busy", int'(busy_m), 0);
      check("reset mincost", int'(min_m), int'(ones_m));
      check("reset matchcount", int'(cnt_m), 0);
      check("reset W", w_m, 0);
      check("reset J", j_m, 0);
    end

    run(0, 8, 2, 1, 2, -1, "n2");

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) c3[i][j] = int'(tbl[t].c[i*3+j]);
      run(1, 26, int'(tbl[t].exp_min), int'(tbl[t].exp_cnt), int'(tbl[t].exp_best), -1, "n3 table");
      if (t == 0) begin
        for (int c = 0; c < 3; c++) begin
          check("n3 first perm W", w_hist[c], c);
          check("n3 first perm J", j_hist[c], c);
        end
      end
    end

    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) c3[i][j] = 1;
    run(2, 26, 3, 3, 36, -1, "n3 saturate");

    // N=4: Start poked while busy must not disturb timing or results.
    run(3, 122, 2, 4, 216, 10, "n4 start ignored");

    // Reset in the middle of ISSUE.
    sel = 3;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("n4 mid-issue W before reset", w_m, 2);
    rst4_x = 1'b1;
    @(posedge clk);
    #1;
    rst4_x = 1'b0;
    check("n4 rst valid", int'(valid_m), 0);
    check("n4 rst busy", int'(busy_m), 0);
    check("n4 rst mincost", int'(min_m), int'(ones_m));
    check("n4 rst matchcount", int'(cnt_m), 0);
    check("n4 rst W", w_m, 0);
    check("n4 rst J", j_m, 0);
    repeat (4) @(posedge clk);
    #1;
    check("n4 idle after rst", int'(busy_m), 0);
    run(3, 122, 2, 4, 216, -1, "n4 after rst");

    // Second run with a different matrix: stale result must not survive.
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) c4[i][j] = 5;
    run(3, 122, 20, 24, 228, -1, "n4 rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
